// File: rtl/tff_bank_counter.sv
// Bank of WIDTH toggle flops sharing a clock: independent per-bit TFFs or a chained-T
// synchronous up/down counter, with parallel load, wrap pulse and per-bit change flags.
module tff_bank_counter #(
  parameter int                 WIDTH     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_t,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_qbar,
  output logic             o_wrap,
  output logic [WIDTH-1:0] o_changed
);

  localparam logic [1:0] MODE_TOGGLE = 2'b00;
  localparam logic [1:0] MODE_UP     = 2'b01;
  localparam logic [1:0] MODE_DOWN   = 2'b10;

  logic [WIDTH-1:0] t_vec;
  logic             wrap_nxt;
  logic             carry;

  // Chained-T: bit k toggles when every lower bit is 1 (up) or 0 (down).
  always_comb begin
    t_vec    = '0;
    wrap_nxt = 1'b0;
    carry    = 1'b1;
    if (i_en) begin
      case (i_mode)
        MODE_TOGGLE: t_vec = i_t;
        MODE_UP: begin
          for (int k = 0; k < WIDTH; k++) begin
            t_vec[k] = carry;
            carry    = carry & o_q[k];
          end
          wrap_nxt = &o_q;
        end
        MODE_DOWN: begin
          for (int k = 0; k < WIDTH; k++) begin
            t_vec[k] = carry;
            carry    = carry & ~o_q[k];
          end
          wrap_nxt = ~|o_q;
        end
        default: t_vec = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_q       <= RESET_VAL;
      o_wrap    <= 1'b0;
      o_changed <= '0;
    end else if (i_load) begin
      o_q       <= i_load_val;
      o_wrap    <= 1'b0;
      o_changed <= o_q ^ i_load_val;
    end else begin
      o_q       <= o_q ^ t_vec;
      o_wrap    <= wrap_nxt;
      o_changed <= t_vec;
    end
  end

  assign o_qbar = ~o_q;

endmodule

// File: tb/tb_tff_bank_counter.sv
// Directed bench for tff_bank_counter at WIDTH=4; a second instance checks RESET_VAL=4'hA.
module tb_tff_bank_counter;

  logic       clk;
  logic       rst;
  logic       i_en;
  logic [1:0] i_mode;
  logic [3:0] i_t;
  logic       i_load;
  logic [3:0] i_load_val;
  logic [3:0] o_q, o_qbar, o_changed;
  logic       o_wrap;
  logic [3:0] a_q, a_qbar, a_changed;
  logic       a_wrap;

  int n_cmp = 0;
  int n_err = 0;
  logic [3:0] exp_q[$];

  tff_bank_counter #(.WIDTH(4), .RESET_VAL(4'h0)) dut (
    .clk(clk), .rst(rst), .i_en(i_en), .i_mode(i_mode), .i_t(i_t),
    .i_load(i_load), .i_load_val(i_load_val),
    .o_q(o_q), .o_qbar(o_qbar), .o_wrap(o_wrap), .o_changed(o_changed)
  );

  tff_bank_counter #(.WIDTH(4), .RESET_VAL(4'hA)) dut_a (
    .clk(clk), .rst(rst), .i_en(i_en), .i_mode(i_mode), .i_t(i_t),
    .i_load(i_load), .i_load_val(i_load_val),
    .o_q(a_q), .o_qbar(a_qbar), .o_wrap(a_wrap), .o_changed(a_changed)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic en, input logic [1:0] mode,
                       input logic [3:0] t, input logic ld, input logic [3:0] ld_val);
    rst = r; i_en = en; i_mode = mode; i_t = t; i_load = ld; i_load_val = ld_val;
  endtask

  // Scoreboard checks
  task automatic check(input string tag, input logic [3:0] q, input logic w,
                       input logic [3:0] chg);
    n_cmp++;
    assert (o_q === q) else begin
      n_err++; $error("FAIL %s o_q got %h exp %h", tag, o_q, q);
    end
    n_cmp++;
    assert (o_qbar === ~q) else begin
      n_err++; $error("FAIL %s o_qbar got %h exp %h", tag, o_qbar, ~q);
    end
    n_cmp++;
    assert (o_wrap === w) else begin
      n_err++; $error("FAIL %s o_wrap got %b exp %b", tag, o_wrap, w);
    end
    n_cmp++;
    assert (o_changed === chg) else begin
      n_err++; $error("FAIL %s o_changed got %h exp %h", tag, o_changed, chg);
    end
  endtask

  initial begin
    logic [3:0] prev;
    logic [3:0] cur;

    // 1: reset
    drive(1'b1, 1'b0, 2'b00, 4'h0, 1'b0, 4'h0);
    tick();
    check("reset", 4'h0, 1'b0, 4'h0);
    n_cmp++;
    assert (a_q === 4'hA && a_qbar === 4'h5 && a_wrap === 1'b0 && a_changed === 4'h0) else begin
      n_err++; $error("FAIL reset_val_a q got %h exp %h", a_q, 4'hA);
    end

    // 2: per-bit toggle
    drive(1'b0, 1'b1, 2'b00, 4'b0101, 1'b0, 4'h0);
    tick(); check("toggle_1", 4'h5, 1'b0, 4'h5);
    tick(); check("toggle_2", 4'h0, 1'b0, 4'h5);
    i_t = 4'h0;
    tick(); check("toggle_hold", 4'h0, 1'b0, 4'h0);
    i_t = 4'hF;
    tick(); check("toggle_all", 4'hF, 1'b0, 4'hF);
    i_t = 4'hF;
    tick(); check("toggle_all_back", 4'h0, 1'b0, 4'hF);

    // 3: up count over 17 edges; i_t is ignored outside toggle mode
    exp_q = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9,
              4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0, 4'h1};
    drive(1'b0, 1'b1, 2'b01, 4'h6, 1'b0, 4'h0);
    prev = 4'h0;
    for (int i = 0; i < 17; i++) begin
      tick();
      cur = exp_q.pop_front();
      check($sformatf("up_%0d", i), cur, (prev == 4'hF && cur == 4'h0), prev ^ cur);
      prev = cur;
    end

    // 4: load then count down through the wrap, with an enable gap
    drive(1'b0, 1'b1, 2'b10, 4'h0, 1'b1, 4'h2);
    tick(); check("load_2", 4'h2, 1'b0, 4'h3);
    i_load = 1'b0;
    tick(); check("down_1", 4'h1, 1'b0, 4'h3);
    tick(); check("down_0", 4'h0, 1'b0, 4'h1);
    tick(); check("down_wrap", 4'hF, 1'b1, 4'hF);
    i_en = 1'b0;
    tick(); check("down_dis", 4'hF, 1'b0, 4'h0);
    i_en = 1'b1;
    tick(); check("down_E", 4'hE, 1'b0, 4'h1);
    i_mode = 2'b11;
    tick(); check("mode_hold", 4'hE, 1'b0, 4'h0);

    // 5: reset beats load; load beats counting
    drive(1'b1, 1'b1, 2'b01, 4'h0, 1'b1, 4'h9);
    tick(); check("rst_over_load", 4'h0, 1'b0, 4'h0);
    rst = 1'b0;
    tick(); check("load_over_up", 4'h9, 1'b0, 4'h9);
    i_load = 1'b0;
    tick(); check("up_after_load", 4'hA, 1'b0, 4'h3);
    i_load = 1'b1; i_load_val = 4'hF; i_en = 1'b0;
    tick(); check("load_while_dis", 4'hF, 1'b0, 4'h5);
    i_load = 1'b0; i_en = 1'b1;
    tick(); check("up_wrap_after_load", 4'h0, 1'b1, 4'hF);

    // 6: reset mid-count at 7, then resume
    for (int i = 1; i <= 7; i++) begin
      tick();
      check($sformatf("count_to7_%0d", i), i[3:0], 1'b0, i[3:0] ^ (i[3:0] - 4'h1));
    end
    rst = 1'b1;
    tick(); check("mid_rst", 4'h0, 1'b0, 4'h0);
    rst = 1'b0;
    tick(); check("resume_1", 4'h1, 1'b0, 4'h1);
    tick(); check("resume_2", 4'h2, 1'b0, 4'h3);

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
